// File: rtl/pipe_hazard_sequencer_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM state encoding, control bundle and widths.
package pipe_hazard_sequencer_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned WAIT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic noop;
    logic flush;
    logic stall;
  } pipe_ctrl_t;

  // IDLE/HALT keep the pipeline frozen and feed bubbles into ID.
  localparam pipe_ctrl_t CTRL_IDLE   = '{pc_write: 1'b0, ifid_write: 1'b0, noop: 1'b1, flush: 1'b0, stall: 1'b1};
  localparam pipe_ctrl_t CTRL_STALL  = '{pc_write: 1'b0, ifid_write: 1'b0, noop: 1'b0, flush: 1'b0, stall: 1'b1};
  localparam pipe_ctrl_t CTRL_BUBBLE = '{pc_write: 1'b0, ifid_write: 1'b0, noop: 1'b1, flush: 1'b0, stall: 1'b0};
  localparam pipe_ctrl_t CTRL_RUN    = '{pc_write: 1'b1, ifid_write: 1'b1, noop: 1'b0, flush: 1'b0, stall: 1'b0};

endpackage

// File: rtl/pipe_hazard_sequencer_load_use_detect.sv
// Combinational load-use compare between the load in EX and the source registers in ID.
module pipe_hazard_sequencer_load_use_detect
  import pipe_hazard_sequencer_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_mem_read_i,
  output logic                  hazard_c
);

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign hazard_c = ex_mem_read_i && (ex_rd_i != '0) &&
                    ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

endmodule

// File: rtl/pipe_hazard_sequencer.sv
// Pipeline sequencer for the 5-stage RISC-V core: start-up, load-use bubbles, branch flush,
// data-memory wait stalls with timeout, and saturating stall/flush performance counters.
module pipe_hazard_sequencer
  import pipe_hazard_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [REG_ADDR_W-1:0] ID_rs1_i,
  input  logic [REG_ADDR_W-1:0] ID_rs2_i,
  input  logic [REG_ADDR_W-1:0] EX_rd_i,
  input  logic                  EX_MemRead_i,
  input  logic                  ID_Branch_i,
  input  logic                  ID_BrTaken_i,
  input  logic                  mem_req_i,
  input  logic                  mem_ack_i,
  output logic                  PCWrite_o,
  output logic                  IFIDWrite_o,
  output logic                  NoOp_o,
  output logic                  Flush_o,
  output logic                  Stall_o,
  output logic                  mem_err_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                mem_err_q, mem_err_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

  logic                memstall_c;
  logic                hazard_c;
  logic                stall_ev_c;
  pipe_ctrl_t          ctrl_c;

  assign memstall_c = mem_req_i && !mem_ack_i;

  pipe_hazard_sequencer_load_use_detect u_load_use_detect (
    .id_rs1_i      (ID_rs1_i),
    .id_rs2_i      (ID_rs2_i),
    .ex_rd_i       (EX_rd_i),
    .ex_mem_read_i (EX_MemRead_i),
    .hazard_c      (hazard_c)
  );

  // State, wait counter, error flag and performance counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next state; an ack in the timeout cycle still returns to RUN without error.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (memstall_c) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack_i) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
          state_d   = ST_HALT;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode; in RUN the memory stall outranks load-use, which outranks the branch flush.
  always_comb begin
    ctrl_c = CTRL_IDLE;
    case (state_q)
      ST_RUN: begin
        if (memstall_c) begin
          ctrl_c = CTRL_STALL;
        end else if (hazard_c) begin
          ctrl_c = CTRL_BUBBLE;
        end else begin
          ctrl_c       = CTRL_RUN;
          ctrl_c.flush = ID_Branch_i && ID_BrTaken_i;
        end
      end
      ST_MEM_WAIT: ctrl_c = CTRL_STALL;
      default:     ctrl_c = CTRL_IDLE;
    endcase
  end

  // Saturating counters; IDLE/HALT decode is never counted.
  assign stall_ev_c = ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) &&
                      (ctrl_c.stall || ctrl_c.noop);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_ev_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (ctrl_c.flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  assign PCWrite_o   = ctrl_c.pc_write;
  assign IFIDWrite_o = ctrl_c.ifid_write;
  assign NoOp_o      = ctrl_c.noop;
  assign Flush_o     = ctrl_c.flush;
  assign Stall_o     = ctrl_c.stall;
  assign mem_err_o   = mem_err_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Self-checking bench for pipe_hazard_sequencer: directed scenarios plus randomized traffic
// compared against a flag-based behavioural model of the sequencing rules.
module tb_pipe_hazard_sequencer;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TO    = 4;
  localparam int          CMAX  = 15;

  logic       clk, rst_n, start;
  logic [4:0] rs1, rs2, ex_rd;
  logic       ex_mr, br, taken, mem_req, mem_ack;
  logic       pc_w, ifid_w, noop, flush, stall, err;
  logic [3:0] stall_cnt, flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  bit m_started, m_waiting, m_halted, m_err;
  int m_wait_len, m_stall_cnt, m_flush_cnt;

  wire [4:0]  ctrl_o  = {pc_w, ifid_w, noop, flush, stall};
  wire [13:0] dut_vec = {pc_w, ifid_w, noop, flush, stall, err, stall_cnt, flush_cnt};

  pipe_hazard_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .start_i      (start),
    .ID_rs1_i     (rs1),
    .ID_rs2_i     (rs2),
    .EX_rd_i      (ex_rd),
    .EX_MemRead_i (ex_mr),
    .ID_Branch_i  (br),
    .ID_BrTaken_i (taken),
    .mem_req_i    (mem_req),
    .mem_ack_i    (mem_ack),
    .PCWrite_o    (pc_w),
    .IFIDWrite_o  (ifid_w),
    .NoOp_o       (noop),
    .Flush_o      (flush),
    .Stall_o      (stall),
    .mem_err_o    (err),
    .stall_cnt_o  (stall_cnt),
    .flush_cnt_o  (flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected {PCWrite, IFIDWrite, NoOp, Flush, Stall} from the model and current inputs.
  function automatic logic [4:0] exp_ctrl();
    logic hz;
    hz = ex_mr && (ex_rd != 5'd0) && ((ex_rd == rs1) || (ex_rd == rs2));
    if (!m_started || m_halted) return 5'b00101;
    if (m_waiting || (mem_req && !mem_ack)) return 5'b00001;
    if (hz) return 5'b00100;
    return {2'b11, 1'b0, br && taken, 1'b0};
  endfunction

  function automatic logic [13:0] exp_vec();
    return {exp_ctrl(), m_err, 4'(m_stall_cnt), 4'(m_flush_cnt)};
  endfunction

  task automatic model_reset();
    m_started = 0; m_waiting = 0; m_halted = 0; m_err = 0;
    m_wait_len = 0; m_stall_cnt = 0; m_flush_cnt = 0;
  endtask

  task automatic model_edge();
    logic [4:0] e;
    e = exp_ctrl();
    if (!m_started) begin
      if (start) m_started = 1;
    end else if (!m_halted) begin
      if ((e[2] || e[0]) && m_stall_cnt < CMAX) m_stall_cnt++;
      if (e[1] && m_flush_cnt < CMAX) m_flush_cnt++;
      if (m_waiting) begin
        if (mem_ack) m_waiting = 0;
        else if (m_wait_len == int'(TO)) begin m_halted = 1; m_err = 1; end
        else m_wait_len++;
      end else if (mem_req && !mem_ack) begin
        m_waiting = 1; m_wait_len = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; rs1 = 5'd1; rs2 = 5'd2; ex_rd = 5'd3; ex_mr = 0;
    br = 0; taken = 0; mem_req = 0; mem_ack = 0;
  endtask

  // Pulse reset, then start so the sequencer is in RUN with zeroed counters.
  task automatic restart();
    rst_n = 0; model_reset(); idle_inputs();
    #1; rst_n = 1; start = 1;
    tick();
    start = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; idle_inputs(); start = 1; model_reset();
    #2;
    n_tests++;
    if (dut_vec !== 14'b00101_0_0000_0000) begin n_fail++; $display("FAIL reset_idle: got %b want %b", dut_vec, 14'b00101_0_0000_0000); end
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (ctrl_o !== 5'b00101) begin n_fail++; $display("FAIL reset_held: got %b want %b", ctrl_o, 5'b00101); end
    rst_n = 1;
    #1;
    n_tests++;
    if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL reset_release: got %b want %b", dut_vec, exp_vec()); end
    tick();
    n_tests++;
    if (pc_w !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL start_run: got pc=%b stall=%b want pc=1 stall=0", pc_w, stall); end
    start = 0;
  endtask

  task automatic test_load_use();
    restart();
    ex_mr = 1; ex_rd = 5'd5; rs1 = 5'd0; rs2 = 5'd5;
    #1;
    n_tests++;
    if (ctrl_o !== 5'b00100) begin n_fail++; $display("FAIL load_use_bubble: got %b want %b", ctrl_o, 5'b00100); end
    tick();
    ex_mr = 0;
    #1;
    n_tests++;
    if (stall_cnt !== 4'd1 || pc_w !== 1'b1) begin n_fail++; $display("FAIL load_use_after: got cnt=%0d pc=%b want cnt=1 pc=1", stall_cnt, pc_w); end
  endtask

  task automatic test_x0();
    restart();
    ex_mr = 1; ex_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    #1;
    n_tests++;
    if (ctrl_o !== 5'b11000) begin n_fail++; $display("FAIL x0_no_hazard: got %b want %b", ctrl_o, 5'b11000); end
    tick();
    n_tests++;
    if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL x0_stall_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_branch();
    restart();
    br = 1; taken = 0;
    #1;
    n_tests++;
    if (flush !== 1'b0) begin n_fail++; $display("FAIL branch_not_taken: got %b want 0", flush); end
    taken = 1;
    #1;
    n_tests++;
    if (ctrl_o !== 5'b11010) begin n_fail++; $display("FAIL branch_flush: got %b want %b", ctrl_o, 5'b11010); end
    tick();
    br = 0; taken = 0;
    #1;
    n_tests++;
    if (flush_cnt !== 4'd1 || flush !== 1'b0) begin n_fail++; $display("FAIL branch_cnt: got cnt=%0d flush=%b want 1/0", flush_cnt, flush); end
  endtask

  task automatic test_hazard_and_branch();
    restart();
    ex_mr = 1; ex_rd = 5'd7; rs1 = 5'd7; br = 1; taken = 1;
    #1;
    n_tests++;
    if (ctrl_o !== 5'b00100) begin n_fail++; $display("FAIL hz_br_bubble: got %b want %b", ctrl_o, 5'b00100); end
    tick();
    ex_mr = 0;
    #1;
    n_tests++;
    if (ctrl_o !== 5'b11010 || stall_cnt !== 4'd1 || flush_cnt !== 4'd0) begin
      n_fail++; $display("FAIL hz_br_resolve: got ctrl=%b sc=%0d fc=%0d want 11010/1/0", ctrl_o, stall_cnt, flush_cnt);
    end
    tick();
    br = 0; taken = 0;
    #1;
    n_tests++;
    if (flush_cnt !== 4'd1) begin n_fail++; $display("FAIL hz_br_flush_cnt: got %0d want 1", flush_cnt); end
  endtask

  task automatic test_mem_wait();
    restart();
    mem_req = 1; mem_ack = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ack = 1;
      #1;
      n_tests++;
      if (ctrl_o !== 5'b00001) begin n_fail++; $display("FAIL mem_wait_stall[%0d]: got %b want %b", i, ctrl_o, 5'b00001); end
      tick();
    end
    mem_req = 0; mem_ack = 0;
    #1;
    n_tests++;
    if (ctrl_o !== 5'b11000 || stall_cnt !== 4'd4 || err !== 1'b0) begin
      n_fail++; $display("FAIL mem_wait_done: got ctrl=%b sc=%0d err=%b want 11000/4/0", ctrl_o, stall_cnt, err);
    end
  endtask

  task automatic test_ack_at_timeout();
    restart();
    mem_req = 1; mem_ack = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) mem_ack = 1;
      tick();
    end
    mem_req = 0; mem_ack = 0;
    #1;
    n_tests++;
    if (err !== 1'b0 || pc_w !== 1'b1 || stall_cnt !== 4'd5) begin
      n_fail++; $display("FAIL ack_at_timeout: got err=%b pc=%b sc=%0d want 0/1/5", err, pc_w, stall_cnt);
    end
  endtask

  task automatic test_timeout();
    restart();
    mem_req = 1; mem_ack = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if (stall !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL timeout_wait[%0d]: got stall=%b err=%b want 1/0", i, stall, err); end
      tick();
    end
    mem_req = 0;
    #1;
    n_tests++;
    if (err !== 1'b1 || ctrl_o !== 5'b00101 || stall_cnt !== 4'd5) begin
      n_fail++; $display("FAIL timeout_halt: got err=%b ctrl=%b sc=%0d want 1/00101/5", err, ctrl_o, stall_cnt);
    end
    start = 1;
    repeat (3) tick();
    n_tests++;
    if (err !== 1'b1 || ctrl_o !== 5'b00101 || stall_cnt !== 4'd5) begin
      n_fail++; $display("FAIL halt_sticky: got err=%b ctrl=%b sc=%0d want 1/00101/5", err, ctrl_o, stall_cnt);
    end
    rst_n = 0; model_reset(); start = 0;
    #1;
    n_tests++;
    if (dut_vec !== 14'b00101_0_0000_0000) begin n_fail++; $display("FAIL halt_reset: got %b want %b", dut_vec, 14'b00101_0_0000_0000); end
    rst_n = 1;
  endtask

  task automatic test_reset_mid_wait();
    restart();
    mem_req = 1;
    repeat (2) tick();
    rst_n = 0; model_reset();
    #1;
    n_tests++;
    if (dut_vec !== 14'b00101_0_0000_0000) begin n_fail++; $display("FAIL reset_mid_wait: got %b want %b", dut_vec, 14'b00101_0_0000_0000); end
    rst_n = 1; mem_req = 0;
    tick();
    n_tests++;
    if (ctrl_o !== 5'b00101 || err !== 1'b0) begin n_fail++; $display("FAIL reset_mid_wait_idle: got ctrl=%b err=%b want 00101/0", ctrl_o, err); end
  endtask

  task automatic test_saturation();
    restart();
    ex_mr = 1; ex_rd = 5'd9; rs1 = 5'd9;
    repeat (20) tick();
    ex_mr = 0; br = 1; taken = 1;
    repeat (20) tick();
    br = 0; taken = 0;
    #1;
    n_tests++;
    if (stall_cnt !== 4'd15 || flush_cnt !== 4'd15) begin
      n_fail++; $display("FAIL saturation: got sc=%0d fc=%0d want 15/15", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_random();
    restart();
    for (int i = 0; i < 600; i++) begin
      start   = ($urandom_range(0, 3) == 0);
      rs1     = 5'($urandom_range(0, 3));
      rs2     = 5'($urandom_range(0, 3));
      ex_rd   = 5'($urandom_range(0, 3));
      ex_mr   = ($urandom_range(0, 2) == 0);
      br      = ($urandom_range(0, 2) == 0);
      taken   = ($urandom_range(0, 1) == 0);
      mem_req = ($urandom_range(0, 3) == 0);
      mem_ack = ($urandom_range(0, 4) < 2);
      #1;
      n_tests++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL random[%0d]: got %b want %b", i, dut_vec, exp_vec()); end
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 0; model_reset();
        #1;
        n_tests++;
        if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL random_reset[%0d]: got %b want %b", i, dut_vec, exp_vec()); end
        rst_n = 1;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0();
    test_branch();
    test_hazard_and_branch();
    test_mem_wait();
    test_ack_at_timeout();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
